// File: rtl/adder_operand_sequencer.sv
// Operand sequencer wrapped around a combinational 16-bit adder.
// It pairs A then B words, registers the result and keeps a saturating overflow count.
// Build option: ADDSEQ_SATURATE_EN clamps the sum to all ones when the addition overflows.
module adder_operand_sequencer #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_carry,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_carry_in,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_overflow,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] ovf_count
);

    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_ADD    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_cin;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_load_a;
    logic                 w_load_b;
    logic                 w_capture;
    logic [WIDTH-1:0]     w_result;
    logic                 w_cnt_at_max;

`ifdef ADDSEQ_SATURATE_EN
    assign w_result = add_overflow ? {WIDTH{1'b1}} : add_sum;
`else
    assign w_result = add_sum;
`endif

    assign w_cnt_at_max = (r_cnt == {CNT_WIDTH{1'b1}});

    // Next-state and Moore handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_capture    = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_a     = 1'b1;
                    w_state_next = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_b     = 1'b1;
                    w_state_next = S_ADD;
                end
            end
            S_ADD: begin
                w_capture    = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_LOAD_A;
                end
            end
            default: begin
                w_state_next = S_LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_a) begin
                r_a <= in_data;
            end
            // Carry-in travels with the B word only
            if (w_load_b) begin
                r_b   <= in_data;
                r_cin <= in_carry;
            end
            if (w_capture) begin
                r_sum <= w_result;
                r_ovf <= add_overflow;
                if (add_overflow && !w_cnt_at_max) begin
                    r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign add_a        = r_a;
    assign add_b        = r_b;
    assign add_carry_in = r_cin;
    assign out_sum      = r_sum;
    assign out_overflow = r_ovf;
    assign ovf_count    = r_cnt;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Randomized self-checking bench for adder_operand_sequencer (8-bit and 2-bit counter instances).
module tb_adder_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_carry;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready,   in_ready_s;
    logic [15:0] add_a,      add_a_s;
    logic [15:0] add_b,      add_b_s;
    logic        add_cin,    add_cin_s;
    logic [15:0] add_sum,    add_sum_s;
    logic        add_ovf,    add_ovf_s;
    logic [15:0] out_sum,    out_sum_s;
    logic        out_ovf,    out_ovf_s;
    logic        out_valid,  out_valid_s;
    logic [7:0]  ovf_count;
    logic [1:0]  ovf_count_s;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;

    always #5 clk = ~clk;

    // Behavioural stand-ins for the external combinational adder
    assign {add_ovf, add_sum}     = 17'(add_a) + 17'(add_b) + 17'(add_cin);
    assign {add_ovf_s, add_sum_s} = 17'(add_a_s) + 17'(add_b_s) + 17'(add_cin_s);

    adder_operand_sequencer #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_carry(in_carry), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_carry_in(add_cin),
        .add_sum(add_sum), .add_overflow(add_ovf),
        .out_sum(out_sum), .out_overflow(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .ovf_count(ovf_count)
    );

    adder_operand_sequencer #(.WIDTH(16), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_carry(in_carry), .in_valid(in_valid), .in_ready(in_ready_s),
        .add_a(add_a_s), .add_b(add_b_s), .add_carry_in(add_cin_s),
        .add_sum(add_sum_s), .add_overflow(add_ovf_s),
        .out_sum(out_sum_s), .out_overflow(out_ovf_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .ovf_count(ovf_count_s)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_sum", 32'(out_sum), 32'd0);
        check_val("rst_out_ovf", 32'(out_ovf), 32'd0);
        check_val("rst_cnt", 32'(ovf_count), 32'd0);
        check_val("rst_cnt_s", 32'(ovf_count_s), 32'd0);
        check_val("rst_add_a", 32'(add_a), 32'd0);
        check_val("rst_add_b", 32'(add_b), 32'd0);
        rst      = 1'b0;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
    endtask

    // Present one word after 'gap' idle cycles; returns at the negedge after acceptance
    task automatic present(input logic [15:0] d, input logic c, input int gap);
        for (int i = 0; i < gap; i++) begin
            check_val("idle_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_data  = d;
        in_carry = c;
        in_valid = 1'b1;
        check_val("in_ready", 32'(in_ready), 32'd1);
        check_val("in_ready_s", 32'(in_ready_s), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_carry = 1'($urandom);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int gap_a, input int gap_b, input int hold);
        int          full;
        logic        exp_ovf;
        logic [15:0] exp_sum;
        full    = int'(a) + int'(b) + int'(cin);
        exp_ovf = (full > 65535);
        exp_sum = 16'(full % 65536);
`ifdef ADDSEQ_SATURATE_EN
        if (exp_ovf) exp_sum = 16'hFFFF;
`endif
        if (exp_ovf) begin
            exp_cnt8 = (exp_cnt8 < 255) ? exp_cnt8 + 1 : 255;
            exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
        end

        present(a, 1'($urandom), gap_a);
        check_val("loadb_add_a", 32'(add_a), 32'(a));
        present(b, cin, gap_b);

        // ADD cycle: operands on the adder, no result yet, junk input must be ignored
        check_val("add_out_valid", 32'(out_valid), 32'd0);
        check_val("add_in_ready", 32'(in_ready), 32'd0);
        check_val("add_a", 32'(add_a), 32'(a));
        check_val("add_b", 32'(add_b), 32'(b));
        check_val("add_cin", 32'(add_cin), 32'(cin));
        in_valid  = 1'b1;
        in_data   = 16'($urandom);
        out_ready = (hold == 0);
        @(negedge clk);

        check_val("out_valid", 32'(out_valid), 32'd1);
        check_val("out_sum", 32'(out_sum), 32'(exp_sum));
        check_val("out_ovf", 32'(out_ovf), 32'(exp_ovf));
        check_val("ovf_count", 32'(ovf_count), 32'(exp_cnt8));
        check_val("ovf_count_s", 32'(ovf_count_s), 32'(exp_cnt2));
        check_val("out_sum_s", 32'(out_sum_s), 32'(exp_sum));
        check_val("done_in_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            @(negedge clk);
            check_val("hold_out_valid", 32'(out_valid), 32'd1);
            check_val("hold_out_sum", 32'(out_sum), 32'(exp_sum));
            check_val("hold_out_ovf", 32'(out_ovf), 32'(exp_ovf));
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_val("hold_add_a", 32'(add_a), 32'(a));
            check_val("hold_add_b", 32'(add_b), 32'(b));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_out_valid", 32'(out_valid), 32'd0);
        check_val("post_in_ready", 32'(in_ready), 32'd1);

        n_txn++;
        $display("txn %0d: A=%04h B=%04h cin=%0d -> sum=%04h ovf=%0d cnt=%0d cnt2=%0d",
                 n_txn, a, b, cin, out_sum, out_ovf, ovf_count, ovf_count_s);
    endtask

    initial begin
        in_data  = '0;
        in_carry = 1'b0;
        do_reset(2);

        do_op(16'd0, 16'd0, 1'b1, 0, 0, 0);
        do_op(16'd12000, 16'd1, 1'b1, 0, 0, 0);
        do_op(16'd1, 16'd13456, 1'b0, 0, 0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1, 2, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 0, 0, 5);

        // Reset while holding a lone A word: it must be discarded
        present(16'd123, 1'b0, 0);
        check_val("partial_add_a", 32'(add_a), 32'd123);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_add_a", 32'(add_a), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_cnt", 32'(ovf_count), 32'd0);
        rst      = 1'b0;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        do_op(16'd7, 16'd9, 1'b0, 0, 0, 0);

        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 0, 0);
        end

        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            do_op(a, b, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 3));
        end

        // Drive the 8-bit counter through its saturation point
        for (int i = 0; i < 260; i++) begin
            do_op(16'hFFFF, 16'($urandom_range(1, 65535)), 1'($urandom), 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
